// File: rtl/instr_fetch_pkg.sv
// Shared sizing for the fetch stage: word width, default memory timeout,
// and the width helper for the timeout counter.
package instr_fetch_pkg;

    localparam int P_WORD_SIZE   = 16;
    localparam int P_MEM_TIMEOUT = 15;

    // The counter must be able to hold MEM_TIMEOUT itself.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/instr_fetch_timer.sv
// Memory-timeout counter for the fetch stage; expires on the cycle whose
// increment would make the count reach MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
module fetch_timer
    import instr_fetch_pkg::*;
#(
    parameter int MEM_TIMEOUT = P_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = timer_width(MEM_TIMEOUT);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{clk, reset_n, i_clr, i_en};
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
            logic [CW-1:0] r_count;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_count <= '0;
                end else if (i_clr) begin
                    r_count <= '0;
                end else if (i_en) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expired = i_en && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads the word at ip over req/ack, hands it to the decoder over
// valid/ready, then returns a step and a one-cycle ip_update to the pointer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int WORD_SIZE   = P_WORD_SIZE,
    parameter int MEM_TIMEOUT = P_MEM_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] ip,
    output logic [WORD_SIZE-1:0] ip_adj,
    output logic                 ip_update,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_offset,
    input  logic                 halt,
    output logic                 fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_ADJ   = 3'd3,
        S_STEP  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_ack;
    logic                 w_accept;
    logic                 w_expired;
    logic                 r_mem_req;
    logic                 r_instr_valid;
    logic                 r_ip_update;
    logic                 r_fault;
    logic [WORD_SIZE-1:0] r_instr;
    logic [WORD_SIZE-1:0] r_ip_adj;

    assign w_ack    = (r_state == S_FETCH) && mem_ack;
    assign w_accept = (r_state == S_HOLD) && instr_ready;

    fetch_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (r_state != S_FETCH),
        .i_en     ((r_state == S_FETCH) && !mem_ack),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!halt) w_next = S_FETCH;
            // An ack in the expiry cycle wins over the timeout.
            S_FETCH: begin
                if (w_ack)          w_next = S_HOLD;
                else if (w_expired) w_next = S_FAULT;
            end
            S_HOLD:  if (w_accept) w_next = S_ADJ;
            S_ADJ:   w_next = S_STEP;
            S_STEP:  w_next = halt ? S_IDLE : S_FETCH;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_ip_update   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_mem_req     <= (w_next == S_FETCH);
            r_instr_valid <= (w_next == S_HOLD);
            r_ip_update   <= (w_next == S_STEP);
            r_fault       <= (w_next == S_FAULT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr  <= '0;
            r_ip_adj <= '0;
        end else begin
            if (w_ack)    r_instr  <= mem_data;
            if (w_accept) r_ip_adj <= branch_taken ? branch_offset : WORD_SIZE'(1);
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = ip;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign ip_adj      = r_ip_adj;
    assign ip_update   = r_ip_update;
    assign fault       = r_fault;

endmodule
